// File: rtl/cnn_pkg.sv
// Shared CNN datapath definitions: element width and the pooling-stage state type.
package cnn_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } pool_state_t;

endpackage

// File: rtl/maxpool2x2_if.sv
// Start/done handshake plus flattened input and pooled maps for the 2x2 max-pool stage.
interface maxpool2x2_if #(
  parameter int MAP_WIDTH = 8,
  parameter int DATA_W    = cnn_pkg::DATA_W
) ();

  localparam int HALF = MAP_WIDTH / 2;

  logic                                start;
  logic [MAP_WIDTH*MAP_WIDTH*DATA_W-1:0] input_map;
  logic [HALF*HALF*DATA_W-1:0]         output_map;
  logic                                busy;
  logic                                done;

  modport master (
    output start,
    output input_map,
    input  output_map,
    input  busy,
    input  done
  );

  modport slave (
    input  start,
    input  input_map,
    output output_map,
    output busy,
    output done
  );

endinterface

// File: rtl/cnn_max4.sv
// Signed maximum of four elements; purely combinational, shared by the pooling stages.
module cnn_max4 #(
  parameter int DATA_W = cnn_pkg::DATA_W
) (
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  input  logic signed [DATA_W-1:0] c,
  input  logic signed [DATA_W-1:0] d,
  output logic signed [DATA_W-1:0] y
);

  logic signed [DATA_W-1:0] max_ab;
  logic signed [DATA_W-1:0] max_cd;

  always_comb begin
    max_ab = (a >= b) ? a : b;
    max_cd = (c >= d) ? c : d;
    y      = (max_ab >= max_cd) ? max_ab : max_cd;
  end

endmodule

// File: rtl/maxpool2x2.sv
// 2x2 stride-2 max pooling over a flattened square map, one output element per RUN cycle.
module maxpool2x2 #(
  parameter int MAP_WIDTH = 8,
  parameter int DATA_W    = cnn_pkg::DATA_W
) (
  input logic         clk,
  input logic         rst_n,
  maxpool2x2_if.slave bus
);

  import cnn_pkg::*;

  localparam int          HALF   = MAP_WIDTH / 2;
  localparam int unsigned HALF_U = HALF;
  localparam int          NOUT   = HALF * HALF;
  localparam int          CW     = (HALF > 1) ? $clog2(HALF) : 1;

  typedef logic [CW-1:0] cnt_t;
  localparam cnt_t LAST = cnt_t'(HALF - 1);

  if ((MAP_WIDTH < 2) || ((MAP_WIDTH % 2) != 0)) begin : g_bad_width
    $error("maxpool2x2: MAP_WIDTH must be even and >= 2");
  end

  pool_state_t state_q, state_d;
  cnt_t        i_q, i_d;
  cnt_t        j_q, j_d;

  logic signed [DATA_W-1:0] a, b, c, d;
  logic signed [DATA_W-1:0] win_max;
  int unsigned              out_idx;
  logic [NOUT*DATA_W-1:0]   out_flat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      i_q     <= '0;
      j_q     <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
    end
  end

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = RUN;
          i_d     = '0;
          j_d     = '0;
        end
      end
      RUN: begin
        if (j_q == LAST) begin
          j_d = '0;
          if (i_q == LAST) begin
            i_d     = '0;
            state_d = DONE;
          end else begin
            i_d = i_q + 1'b1;
          end
        end else begin
          j_d = j_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Window select is a constant-offset mux over all pooled positions, keyed by (i, j).
  always_comb begin
    a = '0;
    b = '0;
    c = '0;
    d = '0;
    for (int unsigned r = 0; r < HALF_U; r++) begin
      for (int unsigned col = 0; col < HALF_U; col++) begin
        if ((r == 32'(i_q)) && (col == 32'(j_q))) begin
          a = bus.input_map[((2*r)*MAP_WIDTH     + 2*col    )*DATA_W +: DATA_W];
          b = bus.input_map[((2*r)*MAP_WIDTH     + 2*col + 1)*DATA_W +: DATA_W];
          c = bus.input_map[((2*r + 1)*MAP_WIDTH + 2*col    )*DATA_W +: DATA_W];
          d = bus.input_map[((2*r + 1)*MAP_WIDTH + 2*col + 1)*DATA_W +: DATA_W];
        end
      end
    end
  end

  cnn_max4 #(.DATA_W(DATA_W)) u_max4 (
    .a (a),
    .b (b),
    .c (c),
    .d (d),
    .y (win_max)
  );

  assign out_idx = 32'(i_q) * HALF_U + 32'(j_q);

  for (genvar e = 0; e < NOUT; e++) begin : g_out
    logic signed [DATA_W-1:0] q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        q <= '0;
      end else if ((state_q == RUN) && (out_idx == 32'(e))) begin
        q <= win_max;
      end
    end

    assign out_flat[e*DATA_W +: DATA_W] = q;
  end

  assign bus.output_map = out_flat;
  assign bus.busy       = (state_q == RUN);
  assign bus.done       = (state_q == DONE);

endmodule

// File: tb/tb_maxpool2x2.sv
// Directed bench for maxpool2x2 at MAP_WIDTH=4 and MAP_WIDTH=2 with hand-computed results.
module tb_maxpool2x2;

  logic clk;
  logic rst_n;

  int checks = 0;
  int errors = 0;

  maxpool2x2_if #(.MAP_WIDTH(4)) bus4 ();
  maxpool2x2_if #(.MAP_WIDTH(2)) bus2 ();

  maxpool2x2 #(.MAP_WIDTH(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4)
  );

  maxpool2x2 #(.MAP_WIDTH(2)) dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic              sel;    // 0: MAP_WIDTH=4 instance, 1: MAP_WIDTH=2 instance
    logic [15:0][31:0] in_e;   // row-major input elements
    logic [3:0][31:0]  exp_e;  // row-major pooled elements
  } vec_t;

  vec_t vecs [5];
  logic [15:0][31:0] ramp;
  logic [15:0][31:0] negs;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%08h), expected %0d (0x%08h)",
               nm, $signed(act), act, $signed(exp), exp);
    end
  endtask

  function automatic logic [31:0] out_el(input logic sel, input int e);
    logic [127:0] m4;
    logic [31:0]  m2;
    m4 = bus4.output_map;
    m2 = bus2.output_map;
    return sel ? m2 : m4[e*32 +: 32];
  endfunction

  function automatic logic busy_of(input logic sel);
    return sel ? bus2.busy : bus4.busy;
  endfunction

  function automatic logic done_of(input logic sel);
    return sel ? bus2.done : bus4.done;
  endfunction

  task automatic set_start(input logic sel, input logic v);
    if (sel) bus2.start = v;
    else     bus4.start = v;
  endtask

  task automatic load(input logic sel, input logic [15:0][31:0] in_e);
    if (sel) bus2.input_map = in_e[3:0];
    else     bus4.input_map = in_e;
  endtask

  // One-cycle start pulse; the next negedge is cycle 1 after the start edge.
  task automatic kick(input logic sel);
    @(negedge clk);
    set_start(sel, 1'b1);
    @(posedge clk);
    #1 set_start(sel, 1'b0);
  endtask

  task automatic run_vec(input logic sel, input logic [15:0][31:0] in_e,
                         input logic [3:0][31:0] exp_e, input string tag);
    int n, done_k, busy_n, done_n;
    n      = sel ? 1 : 4;
    done_k = -1;
    busy_n = 0;
    done_n = 0;
    load(sel, in_e);
    kick(sel);
    for (int k = 1; k <= n + 4; k++) begin
      @(negedge clk);
      if (busy_of(sel)) busy_n++;
      if (done_of(sel)) begin
        done_n++;
        if (done_k < 0) done_k = k;
      end
    end
    check({tag, "_done_lat"}, 32'(done_k), 32'(n + 1));
    check({tag, "_busy_cycles"}, 32'(busy_n), 32'(n));
    check({tag, "_done_pulses"}, 32'(done_n), 32'd1);
    for (int e = 0; e < n; e++)
      check($sformatf("%s_out%0d", tag, e), out_el(sel, e), exp_e[e]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int cnt, first_k, prev_k;

    for (int k = 0; k < 16; k++) begin
      ramp[k] = 32'(k + 1);
      negs[k] = 32'(-(k + 1));
    end

    vecs[0].sel = 1'b0; vecs[0].in_e = ramp;
    vecs[0].exp_e = {32'd16, 32'd14, 32'd8, 32'd6};
    vecs[1].sel = 1'b0; vecs[1].in_e = negs;
    vecs[1].exp_e = {32'(-11), 32'(-9), 32'(-3), 32'(-1)};
    vecs[2].sel = 1'b1; vecs[2].in_e = '0;
    for (int k = 0; k < 4; k++) vecs[2].in_e[k] = 32'h7FFF_FFFF;
    vecs[2].exp_e = {32'd0, 32'd0, 32'd0, 32'h7FFF_FFFF};
    vecs[3].sel = 1'b0;
    vecs[3].in_e = {32'd3, 32'd3, 32'(-7), 32'(-7),
                    32'h8000_0000, 32'h7FFF_FFFF, 32'(-7), 32'(-7),
                    32'd0, 32'd0, 32'(-1), 32'd5,
                    32'd0, 32'd0, 32'd5, 32'h8000_0000};
    vecs[3].exp_e = {32'h7FFF_FFFF, 32'(-7), 32'd0, 32'd5};
    vecs[4].sel = 1'b1; vecs[4].in_e = '0;
    vecs[4].in_e[3:0] = {32'(-4), 32'(-3), 32'(-9), 32'(-5)};
    vecs[4].exp_e = {32'd0, 32'd0, 32'd0, 32'(-3)};

    rst_n          = 1'b0;
    bus4.start     = 1'b0;
    bus2.start     = 1'b0;
    bus4.input_map = '0;
    bus2.input_map = '0;

    #12;
    check("rst_busy4", 32'(bus4.busy), 32'd0);
    check("rst_done4", 32'(bus4.done), 32'd0);
    check("rst_busy2", 32'(bus2.busy), 32'd0);
    for (int e = 0; e < 4; e++) check($sformatf("rst_out4_%0d", e), out_el(1'b0, e), 32'd0);
    check("rst_out2", out_el(1'b1, 0), 32'd0);

    @(negedge clk);
    rst_n = 1'b1;

    for (int v = 0; v < 5; v++)
      run_vec(vecs[v].sel, vecs[v].in_e, vecs[v].exp_e, $sformatf("v%0d", v));

    // Elements not yet rewritten keep the previous run's values.
    run_vec(1'b0, ramp, vecs[0].exp_e, "pre");
    load(1'b0, negs);
    kick(1'b0);
    @(negedge clk);
    check("keep_k1_out0", out_el(1'b0, 0), 32'd6);
    check("keep_k1_out3", out_el(1'b0, 3), 32'd16);
    check("keep_k1_busy", 32'(bus4.busy), 32'd1);
    @(negedge clk);
    check("keep_k2_out0", out_el(1'b0, 0), 32'(-1));
    check("keep_k2_out1", out_el(1'b0, 1), 32'd8);
    cnt = 0;
    for (int k = 3; k <= 10; k++) begin
      @(negedge clk);
      if (bus4.done) cnt++;
    end
    check("keep_done_pulses", 32'(cnt), 32'd1);
    for (int e = 0; e < 4; e++) check($sformatf("keep_out%0d", e), out_el(1'b0, e), vecs[1].exp_e[e]);

    // start asserted during RUN cycles 2 and 3 is ignored.
    load(1'b0, ramp);
    kick(1'b0);
    cnt = 0;
    first_k = -1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (bus4.done) begin
        cnt++;
        if (first_k < 0) first_k = k;
      end
      if (k == 2) bus4.start = 1'b1;
      if (k == 4) bus4.start = 1'b0;
    end
    check("ign_done_pulses", 32'(cnt), 32'd1);
    check("ign_done_lat", 32'(first_k), 32'd5);
    for (int e = 0; e < 4; e++) check($sformatf("ign_out%0d", e), out_el(1'b0, e), vecs[0].exp_e[e]);

    // Asynchronous reset during RUN cycle 2 aborts the run.
    load(1'b0, negs);
    kick(1'b0);
    @(negedge clk);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(bus4.busy), 32'd0);
    check("arst_done", 32'(bus4.done), 32'd0);
    for (int e = 0; e < 4; e++) check($sformatf("arst_out%0d", e), out_el(1'b0, e), 32'd0);
    check("arst_out2", out_el(1'b1, 0), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (bus4.done || bus4.busy) cnt++;
    end
    check("arst_no_activity", 32'(cnt), 32'd0);
    run_vec(1'b0, ramp, vecs[0].exp_e, "post_rst");

    // start held high for 20 cycles: back-to-back runs with period N+2.
    load(1'b0, negs);
    @(negedge clk);
    bus4.start = 1'b1;
    cnt     = 0;
    first_k = -1;
    prev_k  = -1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (k == 20) bus4.start = 1'b0;
      if (bus4.done) begin
        cnt++;
        if (first_k < 0) first_k = k;
        if (prev_k > 0) check($sformatf("hold_period%0d", cnt), 32'(k - prev_k), 32'd6);
        prev_k = k;
        for (int e = 0; e < 4; e++)
          check($sformatf("hold_run%0d_out%0d", cnt, e), out_el(1'b0, e), vecs[1].exp_e[e]);
      end
    end
    check("hold_done_pulses", 32'(cnt), 32'd4);
    check("hold_first_done", 32'(first_k), 32'd5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
